// File: rtl/miriscv_alu_pkg.sv
// Shared definitions for the miriscv ALU and its arbiter: opcode map,
// default widths, the arbiter state type and an opcode legality helper.
package miriscv_alu_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00001;
  localparam logic [OP_W-1:0] ALU_SUB = 5'b00010;
  localparam logic [OP_W-1:0] ALU_XOR = 5'b00011;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00100;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_SRA = 5'b00110;
  localparam logic [OP_W-1:0] ALU_SRL = 5'b00111;
  localparam logic [OP_W-1:0] ALU_SLL = 5'b01000;
  localparam logic [OP_W-1:0] ALU_LTS = 5'b01001;
  localparam logic [OP_W-1:0] ALU_LTU = 5'b01010;
  localparam logic [OP_W-1:0] ALU_GES = 5'b01011;
  localparam logic [OP_W-1:0] ALU_GEU = 5'b01100;
  localparam logic [OP_W-1:0] ALU_EQ  = 5'b01101;
  localparam logic [OP_W-1:0] ALU_NE  = 5'b01110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Legal opcodes form one contiguous block, ADD through NE.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op >= ALU_ADD) && (op <= ALU_NE);
  endfunction

endpackage

// File: rtl/miriscv_rr_arbiter.sv
// Combinational round-robin pick: first requesting bit strictly after the
// last served index, wrapping around.
module miriscv_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  // Scan NUM_REQ positions starting one past the last grant.
  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the scan, so no path leaves a
    // value unassigned and no latch is inferred.
    idx         = '0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last_i) + i) % NUM_REQ);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
    gnt_o[gnt_idx_o] = gnt_valid_o;
  end

endmodule

// File: rtl/miriscv_alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters. One operation is in
// flight at a time: IDLE accepts, EXEC drives the ALU, RESP holds the
// registered result until the granted requester consumes it.
module miriscv_alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]   req_operator_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_b_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_flag_o,
  output logic                      rsp_err_o,
  output logic [OP_W-1:0]           alu_operator_o,
  output logic [DATA_W-1:0]         alu_operand_a_o,
  output logic [DATA_W-1:0]         alu_operand_b_o,
  input  logic [DATA_W-1:0]         alu_result_i,
  input  logic                      alu_comparison_result_i,
  output logic                      busy_o
);

  import miriscv_alu_pkg::state_e;
  import miriscv_alu_pkg::IDLE;
  import miriscv_alu_pkg::EXEC;
  import miriscv_alu_pkg::RESP;
  import miriscv_alu_pkg::is_legal_op;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                flag_q, flag_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  logic [OP_W-1:0]     op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_arr[k] = req_operator_i[k*OP_W +: OP_W];
    assign a_arr[k]  = req_operand_a_i[k*DATA_W +: DATA_W];
    assign b_arr[k]  = req_operand_b_i[k*DATA_W +: DATA_W];
  end

  miriscv_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i       (req_valid_i),
    .last_i      (last_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // State and datapath registers; last grant resets to the top index so
  // requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

  // Next-state and register-update logic; everything holds unless changed.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          op_d    = op_arr[arb_idx];
          a_d     = a_arr[arb_idx];
          b_d     = b_arr[arb_idx];
          gnt_d   = arb_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_legal_op(op_q)) begin
          result_d = alu_result_i;
          flag_d   = alu_comparison_result_i;
          err_d    = 1'b0;
        end else begin
          result_d = '0;
          flag_d   = 1'b0;
          err_d    = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs. Ready is also masked by reset so every output reads
  // zero while reset is held, even with requests pending.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if ((state_q == IDLE) && arstn_i) req_ready_o = arb_gnt;
    if (state_q == RESP) rsp_valid_o[gnt_q] = 1'b1;
  end

  assign busy_o          = (state_q != IDLE);
  assign rsp_result_o    = result_q;
  assign rsp_flag_o      = flag_q;
  assign rsp_err_o       = err_q;
  assign alu_operator_o  = op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;

endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// Self-checking bench for miriscv_alu_arbiter with a behavioural ALU and a
// reference model of grant order and response contents.
module tb_miriscv_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = 5;

  localparam logic [OW-1:0] OP_ADD = 5'd1;
  localparam logic [OW-1:0] OP_SUB = 5'd2;
  localparam logic [OW-1:0] OP_XOR = 5'd3;
  localparam logic [OW-1:0] OP_AND = 5'd5;
  localparam logic [OW-1:0] OP_LTS = 5'd9;
  localparam logic [OW-1:0] OP_LTU = 5'd10;
  localparam logic [OW-1:0] OP_EQ  = 5'd13;

  logic            clk_i   = 1'b0;
  logic            arstn_i = 1'b0;
  logic [N-1:0]    req_valid_i     = '0;
  logic [N-1:0]    rsp_ready_i     = '0;
  logic [N*OW-1:0] req_operator_i  = '0;
  logic [N*DW-1:0] req_operand_a_i = '0;
  logic [N*DW-1:0] req_operand_b_i = '0;
  logic [N-1:0]    req_ready_o, rsp_valid_o;
  logic [DW-1:0]   rsp_result_o;
  logic            rsp_flag_o, rsp_err_o, busy_o;
  logic [OW-1:0]   alu_operator_o;
  logic [DW-1:0]   alu_operand_a_o, alu_operand_b_o;
  logic [DW-1:0]   alu_result_i;
  logic            alu_comparison_result_i;

  int tests = 0;
  int fails = 0;

  logic [OW-1:0] op_m [N];
  logic [DW-1:0] a_m  [N];
  logic [DW-1:0] b_m  [N];
  int            last_m = N - 1;

  miriscv_alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk_i                   (clk_i),
    .arstn_i                 (arstn_i),
    .req_valid_i             (req_valid_i),
    .req_ready_o             (req_ready_o),
    .req_operator_i          (req_operator_i),
    .req_operand_a_i         (req_operand_a_i),
    .req_operand_b_i         (req_operand_b_i),
    .rsp_valid_o             (rsp_valid_o),
    .rsp_ready_i             (rsp_ready_i),
    .rsp_result_o            (rsp_result_o),
    .rsp_flag_o              (rsp_flag_o),
    .rsp_err_o               (rsp_err_o),
    .alu_operator_o          (alu_operator_o),
    .alu_operand_a_o         (alu_operand_a_o),
    .alu_operand_b_o         (alu_operand_b_o),
    .alu_result_i            (alu_result_i),
    .alu_comparison_result_i (alu_comparison_result_i),
    .busy_o                  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU: {flag, result}. Illegal codes return junk on purpose.
  function automatic logic [DW:0] alu_fn(input logic [OW-1:0] op,
                                         input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          f;
    r = '0;
    f = 1'b0;
    case (op)
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a ^ b;
      5'd4:  r = a | b;
      5'd5:  r = a & b;
      5'd6:  r = $signed(a) >>> b[4:0];
      5'd7:  r = a >> b[4:0];
      5'd8:  r = a << b[4:0];
      5'd9:  f = $signed(a) < $signed(b);
      5'd10: f = a < b;
      5'd11: f = $signed(a) >= $signed(b);
      5'd12: f = a >= b;
      5'd13: f = a == b;
      5'd14: f = a != b;
      default: begin r = 32'hDEAD_BEEF; f = 1'b1; end
    endcase
    if (op >= 5'd9 && op <= 5'd14) r = {{(DW-1){1'b0}}, f};
    return {f, r};
  endfunction

  always_comb {alu_comparison_result_i, alu_result_i} =
    alu_fn(alu_operator_o, alu_operand_a_o, alu_operand_b_o);

  // Expected response {err, flag, result} for a request payload.
  function automatic logic [DW+1:0] expect_rsp(input logic [OW-1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    if (op >= 5'd1 && op <= 5'd14) return {1'b0, alu_fn(op, a, b)};
    return {1'b1, 1'b0, {DW{1'b0}}};
  endfunction

  // Next requester per round robin: first valid after the last served one.
  function automatic int model_pick();
    for (int i = 1; i <= N; i++)
      if (req_valid_i[(last_m + i) % N]) return (last_m + i) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  req_ready_o, 0);
    check({tag, "_rvalid"}, rsp_valid_o, 0);
    check({tag, "_result"}, rsp_result_o, 0);
    check({tag, "_flag"},   rsp_flag_o, 0);
    check({tag, "_err"},    rsp_err_o, 0);
    check({tag, "_aluop"},  alu_operator_o, 0);
    check({tag, "_alua"},   alu_operand_a_o, 0);
    check({tag, "_alub"},   alu_operand_b_o, 0);
    check({tag, "_busy"},   busy_o, 0);
  endtask

  task automatic raise(input int k, input logic [OW-1:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_m[k] = op;
    a_m[k]  = a;
    b_m[k]  = b;
    req_operator_i[k*OW +: OW]  = op;
    req_operand_a_i[k*DW +: DW] = a;
    req_operand_b_i[k*DW +: DW] = b;
    req_valid_i[k] = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input logic [N-1:0] oh, input logic [DW+1:0] e);
    check({tag, "_rvalid"}, rsp_valid_o, oh);
    check({tag, "_result"}, rsp_result_o, e[DW-1:0]);
    check({tag, "_flag"},   rsp_flag_o, e[DW]);
    check({tag, "_err"},    rsp_err_o, e[DW+1]);
    check({tag, "_ready"},  req_ready_o, 0);
    check({tag, "_busy"},   busy_o, 1);
  endtask

  // One full transaction starting in IDLE at a negedge; bp = response stall cycles.
  task automatic serve_one(input int bp, output int g);
    logic [DW+1:0] e;
    logic [N-1:0]  oh;
    g = model_pick();
    if (g < 0) g = 0;
    oh = '0;
    oh[g] = 1'b1;
    e = expect_rsp(op_m[g], a_m[g], b_m[g]);
    #1;
    check("grant", req_ready_o, oh);
    check("idle_busy", busy_o, 0);
    @(posedge clk_i); @(negedge clk_i);
    req_valid_i[g] = 1'b0;
    #1;
    check("exec_ready", req_ready_o, 0);
    check("exec_busy", busy_o, 1);
    check("exec_rvalid", rsp_valid_o, 0);
    check("exec_aluop", alu_operator_o, op_m[g]);
    check("exec_alua", alu_operand_a_o, a_m[g]);
    check("exec_alub", alu_operand_b_o, b_m[g]);
    @(posedge clk_i); @(negedge clk_i);
    for (int c = 0; c < bp; c++) begin
      rsp_ready_i = N'($urandom()) & ~oh;
      #1;
      check_rsp("stall", oh, e);
      @(posedge clk_i); @(negedge clk_i);
    end
    rsp_ready_i = oh | N'($urandom());
    #1;
    check_rsp("hs", oh, e);
    check("hs_alua", alu_operand_a_o, a_m[g]);
    @(posedge clk_i); @(negedge clk_i);
    rsp_ready_i = '0;
    last_m = g;
    #1;
    check("post_busy", busy_o, 0);
    check("post_rvalid", rsp_valid_o, 0);
    check("post_aluop", alu_operator_o, op_m[g]);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arstn_i = 1'b0;
    #1;
    check_all_zero("rst");
    @(posedge clk_i); @(negedge clk_i);
    arstn_i = 1'b1;
    last_m  = N - 1;
  endtask

  // Requester protocol: valid must not drop before it was accepted.
  logic [N-1:0] pv = '0;
  logic [N-1:0] pr = '0;
  logic         pok = 1'b0;
  always begin
    @(negedge clk_i);
    #4;
    if (arstn_i && pok)
      for (int k = 0; k < N; k++)
        assert (!(pv[k] && !pr[k] && !req_valid_i[k])) else begin
          fails++;
          $error("FAIL protocol: req %0d dropped valid without handshake", k);
        end
    pv  = req_valid_i;
    pr  = req_ready_o;
    pok = arstn_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [OW-1:0] op;

    // Power-on reset, with requests pending to show ready is masked.
    @(negedge clk_i);
    req_valid_i = '1;
    #1;
    check_all_zero("por");
    req_valid_i = '0;
    @(posedge clk_i); @(negedge clk_i);
    arstn_i = 1'b1;
    last_m  = N - 1;

    // Single op: 50 + 34.
    raise(0, OP_ADD, 32'd50, 32'd34);
    serve_one(0, g);

    // Contention from a fresh reset: req0 first, then req1.
    do_reset();
    raise(0, OP_SUB, 32'd1, 32'd1);
    raise(1, OP_XOR, 32'd50, 32'd34);
    serve_one(0, g);
    serve_one(0, g);

    // Sustained traffic from both requesters.
    raise(0, OP_ADD, $urandom(), $urandom());
    raise(1, OP_AND, $urandom(), $urandom());
    for (int i = 0; i < 6; i++) begin
      serve_one(0, g);
      raise(g, OW'($urandom_range(1, 14)), $urandom(), $urandom());
    end
    for (int i = 0; i < 2; i++) serve_one(0, g);

    // Backpressure on req0 while req1 waits.
    do_reset();
    raise(0, OP_ADD, 32'd7, 32'd8);
    raise(1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    serve_one(5, g);
    serve_one(0, g);

    // Comparisons.
    raise(0, OP_LTS, 32'hFFFF_FEBF, 32'd100);
    serve_one(1, g);
    raise(0, OP_LTU, 32'hFFFF_FEBF, 32'd100);
    serve_one(0, g);
    raise(0, OP_EQ, 32'd0, 32'd0);
    serve_one(0, g);

    // Illegal operators.
    raise(1, 5'd0, 32'd3, 32'd4);
    serve_one(2, g);
    raise(1, 5'd20, 32'd3, 32'd4);
    serve_one(0, g);

    // Randomized traffic.
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < N; k++)
        if (!req_valid_i[k] && ($urandom_range(0, 1) == 1)) begin
          op = ($urandom_range(0, 3) == 0) ? OW'($urandom_range(0, 31))
                                           : OW'($urandom_range(1, 14));
          raise(k, op, $urandom(), $urandom());
        end
      if (req_valid_i == '0) raise(int'($urandom_range(0, N-1)), OP_ADD, $urandom(), $urandom());
      while (req_valid_i != '0) serve_one(int'($urandom_range(0, 3)), g);
    end

    // Reset while in EXEC: transaction dropped, req0 served first after.
    raise(1, OP_ADD, 32'd1, 32'd2);
    raise(0, OP_SUB, 32'd9, 32'd4);
    g = model_pick();
    #1;
    check("midop_grant", req_ready_o, N'(1) << g);
    @(posedge clk_i); @(negedge clk_i);
    #1;
    check("midop_exec_busy", busy_o, 1);
    arstn_i = 1'b0;
    #1;
    check_all_zero("midop");
    @(posedge clk_i); @(negedge clk_i);
    arstn_i = 1'b1;
    last_m  = N - 1;
    #1;
    check("release_rvalid", rsp_valid_o, 0);
    serve_one(0, g);
    check("release_first", g, 0);
    serve_one(0, g);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
